reg_write_port: RTL and testbench

- Write side of the 32 x 32-bit general register file; counterpart to the clocked read multiplexer.
- Accepts write-back requests over a valid/ready handshake into a 2-entry buffer and commits at most one per cycle into register storage, with per-byte enables.
- Drives all register contents as one flattened bus that feeds the read multiplexer's R0..R31 inputs.
- Publishes each commit for hazard/forwarding logic.

---
 rtl/reg_write_port_pkg.sv | 24 ++
 rtl/reg_write_port_if.sv | 26 ++
 rtl/reg_write_port_wr_fifo.sv | 44 ++++
 rtl/reg_write_port.sv | 54 +++++
 tb/tb_reg_write_port.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/reg_write_port_pkg.sv
// reg_write_port_pkg: shared register-file constants, write-buffer entry type and byte-merge helper
package reg_write_port_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam bit ZERO_REG = 1'b1;
   localparam int DEPTH    = 2;
   localparam int MASK_W   = DATA_W / 8;
   localparam int CNT_W    = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
   } entry_t;

   // Replace only the bytes whose mask bit is set; the rest keep the old value.
   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] din,
                                               input logic [MASK_W-1:0] mask);
      merge = old;
      for (int i = 0; i < MASK_W; i++)
         if (mask[i]) merge[8*i +: 8] = din[8*i +: 8];
   endfunction
endpackage

// File: rtl/reg_write_port_if.sv
// reg_write_port_if: write-request handshake, control and register/commit outputs of the write port
//   master drives wr_valid/wr_add/wr_data/wr_mask/stall/clear; slave drives wr_ready/regs/commit_*/pending
interface reg_write_port_if;
   import reg_write_port_pkg::*;
   logic                         wr_valid;
   logic                         wr_ready;
   logic [ADDR_W-1:0]            wr_add;
   logic [DATA_W-1:0]            wr_data;
   logic [MASK_W-1:0]            wr_mask;
   logic                         stall;
   logic                         clear;
   logic [NUM_REGS*DATA_W-1:0]   regs;
   logic                         commit_valid;
   logic [ADDR_W-1:0]            commit_add;
   logic [DATA_W-1:0]            commit_data;
   logic [CNT_W-1:0]             pending;

   modport master (
      output wr_valid, wr_add, wr_data, wr_mask, stall, clear,
      input  wr_ready, regs, commit_valid, commit_add, commit_data, pending
   );
   modport slave (
      input  wr_valid, wr_add, wr_data, wr_mask, stall, clear,
      output wr_ready, regs, commit_valid, commit_add, commit_data, pending
   );
endinterface

// File: rtl/reg_write_port_wr_fifo.sv
// wr_fifo: DEPTH-entry synchronous FIFO with push/pop, flush, full/empty and count
//   clk, rst_n (async active-low); push/din at tail; pop/dout at head; flush empties it
module wr_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;

   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end

   always_ff @(posedge clk)
      if (push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/reg_write_port.sv
// reg_write_port: buffered, byte-masked write side of the 32x32 register file
//   clk, rst_n (async active-low); bus.slave carries the write handshake, stall/clear,
//   the flattened register contents, the registered commit report and the buffer occupancy
module reg_write_port
   import reg_write_port_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   reg_write_port_if.slave  bus
);
   logic [NUM_REGS-1:0][DATA_W-1:0] rf;
   entry_t                          head;
   logic                            full, empty, push, pop, zero;
   logic [DATA_W-1:0]               merged;

   assign bus.wr_ready = ~full & ~bus.clear;
   assign push         = bus.wr_valid & bus.wr_ready;
   assign pop          = ~empty & ~bus.stall & ~bus.clear;
   assign zero         = ZERO_REG && head.addr == '0;
   // Register 0 reports zero and is never written, so its storage stays at its reset value.
   assign merged       = zero ? '0 : merge(rf[head.addr], head.data, head.mask);
   assign bus.regs     = rf;

   wr_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (bus.clear),
      .din   ({bus.wr_add, bus.wr_data, bus.wr_mask}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (bus.pending)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rf               <= '0;
         bus.commit_valid <= 1'b0;
         bus.commit_add   <= '0;
         bus.commit_data  <= '0;
      end else if (bus.clear) begin
         rf               <= '0;
         bus.commit_valid <= 1'b0;
      end else begin
         bus.commit_valid <= pop;
         if (pop) begin
            if (!zero) rf[head.addr] <= merged;
            bus.commit_add  <= head.addr;
            bus.commit_data <= merged;
         end
      end
endmodule

// File: tb/tb_reg_write_port.sv
// tb_reg_write_port: directed self-checking bench for reg_write_port
module tb_reg_write_port;
   import reg_write_port_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;

   reg_write_port_if bus ();
   reg_write_port dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rd(input int k);
      return bus.regs[k*DATA_W +: DATA_W];
   endfunction

   task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [MASK_W-1:0] m);
      bus.wr_valid = v;
      bus.wr_add   = a;
      bus.wr_data  = d;
      bus.wr_mask  = m;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      drive(0, 0, 0, 0);
      bus.stall = 0;
      bus.clear = 0;
      #12;
      check("rst_pending", bus.pending, 0);
      check("rst_cvalid", bus.commit_valid, 0);
      check("rst_regs", {63'd0, |bus.regs}, 0);
      rst_n = 1;
      check("rst_ready", bus.wr_ready, 1);
      tick();
      // single write, one-edge latency
      drive(1, 5, 32'hDEADBEEF, 4'hF);
      tick();
      drive(0, 0, 0, 0);
      check("single_pend1", bus.pending, 1);
      check("single_notyet", rd(5), 0);
      tick();
      check("single_reg5", bus.regs[191:160], 32'hDEADBEEF);
      check("single_cvalid", bus.commit_valid, 1);
      check("single_cadd", bus.commit_add, 5);
      check("single_cdata", bus.commit_data, 32'hDEADBEEF);
      check("single_pend0", bus.pending, 0);
      tick();
      check("single_pulse", bus.commit_valid, 0);
      // byte mask, back-to-back
      drive(1, 7, 32'h11223344, 4'hF);
      tick();
      drive(1, 7, 32'hAABBCCDD, 4'h5);
      tick();
      drive(0, 0, 0, 0);
      check("mask_pend_simul", bus.pending, 1);
      check("mask_first", rd(7), 32'h11223344);
      tick();
      check("mask_reg7", rd(7), 32'h11BB33DD);
      check("mask_cdata", bus.commit_data, 32'h11BB33DD);
      // stall / full
      bus.stall = 1;
      drive(1, 1, 32'h101, 4'hF);
      tick();
      check("full_pend1", bus.pending, 1);
      drive(1, 2, 32'h202, 4'hF);
      tick();
      check("full_pend2", bus.pending, 2);
      check("full_ready0", bus.wr_ready, 0);
      drive(1, 3, 32'h303, 4'hF);
      tick();
      check("full_held", bus.pending, 2);
      check("full_nocommit", rd(1), 0);
      bus.stall = 0;
      tick();
      check("full_c1", bus.commit_add, 1);
      check("full_c1pend", bus.pending, 1);
      check("full_ready1", bus.wr_ready, 1);
      tick();
      drive(0, 0, 0, 0);
      check("full_c2", bus.commit_add, 2);
      check("full_c2pend", bus.pending, 1);
      tick();
      check("full_c3", bus.commit_add, 3);
      check("full_c3pend", bus.pending, 0);
      check("full_r123", {rd(1), rd(2)}, {32'h101, 32'h202});
      check("full_r3", rd(3), 32'h303);
      // zero register
      drive(1, 0, 32'h5, 4'hF);
      tick();
      drive(0, 0, 0, 0);
      tick();
      check("zero_cvalid", bus.commit_valid, 1);
      check("zero_cdata", bus.commit_data, 0);
      check("zero_reg0", bus.regs[31:0], 0);
      // ordering to the same register
      bus.stall = 1;
      drive(1, 9, 32'h1, 4'hF);
      tick();
      drive(1, 9, 32'h2, 4'hF);
      tick();
      drive(0, 0, 0, 0);
      bus.stall = 0;
      tick();
      check("order_first", bus.commit_data, 1);
      tick();
      check("order_last", rd(9), 2);
      // all-zero mask
      drive(1, 7, 32'hFFFFFFFF, 4'h0);
      tick();
      drive(0, 0, 0, 0);
      tick();
      check("mask0_cvalid", bus.commit_valid, 1);
      check("mask0_cdata", bus.commit_data, 32'h11BB33DD);
      check("mask0_reg7", rd(7), 32'h11BB33DD);
      // clear with buffered data
      bus.stall = 1;
      drive(1, 4, 32'h44, 4'hF);
      tick();
      drive(1, 6, 32'h66, 4'hF);
      tick();
      drive(0, 0, 0, 0);
      bus.clear = 1;
      #1;
      check("clr_ready0", bus.wr_ready, 0);
      tick();
      bus.clear = 0;
      bus.stall = 0;
      check("clr_pend", bus.pending, 0);
      check("clr_regs", {63'd0, |bus.regs}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("clr_nocommit", bus.commit_valid, 0);
      end
      check("clr_r4r6", {rd(4), rd(6)}, 0);
      // async reset mid-stream
      drive(1, 10, 32'hA, 4'hF);
      tick();
      drive(1, 11, 32'hB, 4'hF);
      tick();
      check("ar_pre_cvalid", bus.commit_valid, 1);
      check("ar_pre_reg10", rd(10), 32'hA);
      #2;
      rst_n = 0;
      #1;
      check("ar_pend", bus.pending, 0);
      check("ar_cvalid", bus.commit_valid, 0);
      check("ar_cadd", bus.commit_add, 0);
      check("ar_cdata", bus.commit_data, 0);
      check("ar_regs", {63'd0, |bus.regs}, 0);
      drive(0, 0, 0, 0);
      #3;
      rst_n = 1;
      tick();
      check("ar_ready", bus.wr_ready, 1);
      check("ar_lost", bus.pending, 0);
      tick();
      check("ar_nocommit", bus.commit_valid, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
